// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and BCD helper functions for the up/down BCD counter.
package bcd_updown_counter_pkg;

  localparam logic [3:0] BCD_NINE   = 4'h9;
  localparam int         MAX_DIGITS = 8;

  // True when each of the low `digits` nibbles of v is a legal BCD digit.
  function automatic logic is_bcd(input logic [31:0] v, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && v[4*i +: 4] > BCD_NINE) ok = 1'b0;
    end
    return ok;
  endfunction

  // All-nines terminal value for a counter of `digits` digits.
  function automatic logic [31:0] all_nines(input int digits);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) v[4*i +: 4] = BCD_NINE;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle of one counter; the master drives strobes and data.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
) ();

  logic                  en;
  logic                  up;
  logic                  ld;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  lderr;

  modport master (output en, up, ld, d, input q, tc, lderr);
  modport slave  (input en, up, ld, d, output q, tc, lderr);

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit register with load, wrap and single-step inc/dec.
module bcd_updown_counter_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_ld,
  input  logic [3:0] i_ld_val,
  input  logic       i_wrap,
  input  logic [3:0] i_wrap_val,
  output logic [3:0] o_q,
  output logic       o_is9,
  output logic       o_is0
);

  logic [3:0] r_q;

  // Digit update: load beats wrap, wrap beats stepping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= 4'h0;
    end else if (i_ld) begin
      r_q <= i_ld_val;
    end else if (i_wrap) begin
      r_q <= i_wrap_val;
    end else if (i_inc) begin
      r_q <= (r_q == BCD_NINE) ? 4'h0 : r_q + 4'h1;
    end else if (i_dec) begin
      r_q <= (r_q == 4'h0) ? BCD_NINE : r_q - 4'h1;
    end
  end

  assign o_q   = r_q;
  assign o_is9 = (r_q == BCD_NINE);
  assign o_is0 = (r_q == 4'h0);

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with programmable terminal value, validated
// parallel load and a combinational cascade terminal-count output.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int          DIGITS = 4,
  parameter logic [31:0] MAX    = all_nines(DIGITS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  bcd_updown_counter_if.slave bus
);

  localparam int             W     = 4 * DIGITS;
  localparam logic [W-1:0]   MAX_W = MAX[W-1:0];

  // Reject an out-of-range digit count or a terminal value that is not BCD
  // or has bits set above the counter width.
  generate
    if (DIGITS < 1 || DIGITS > MAX_DIGITS || !is_bcd(MAX, DIGITS) || (MAX >> W) != 32'd0) begin : g_bad_max
      $error("bcd_updown_counter: illegal DIGITS or MAX");
    end
  endgenerate

  logic [W-1:0]      w_q;
  logic [W-1:0]      w_wrap_val;
  logic [DIGITS-1:0] w_is9;
  logic [DIGITS-1:0] w_is0;
  logic [DIGITS-1:0] w_inc;
  logic [DIGITS-1:0] w_dec;
  logic              w_max_hit;
  logic              w_zero;
  logic              w_d_ok;
  logic              w_ld_ok;
  logic              w_cnt_up;
  logic              w_cnt_dn;
  logic              w_wrap;
  logic              w_unused_msd;
  logic              r_lderr;

  assign w_max_hit  = (w_q == MAX_W);
  assign w_zero     = (w_q == '0);

  // Packed BCD orders like plain binary, so a magnitude compare suffices.
  assign w_d_ok     = is_bcd(32'(bus.d), DIGITS) && (bus.d <= MAX_W);
  assign w_ld_ok    = bus.ld & w_d_ok;

  // Counting only happens in non-load cycles; a rejected load also holds.
  assign w_cnt_up   = bus.en & ~bus.ld & bus.up;
  assign w_cnt_dn   = bus.en & ~bus.ld & ~bus.up;
  assign w_wrap     = (w_cnt_up & w_max_hit) | (w_cnt_dn & w_zero);
  assign w_wrap_val = bus.up ? '0 : MAX_W;

  // The top digit's flags do not feed any higher stage.
  assign w_unused_msd = w_is9[DIGITS-1] | w_is0[DIGITS-1];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign w_inc[gi] = w_cnt_up;
        assign w_dec[gi] = w_cnt_dn;
      end else begin : g_chain
        assign w_inc[gi] = w_inc[gi-1] & w_is9[gi-1];
        assign w_dec[gi] = w_dec[gi-1] & w_is0[gi-1];
      end

      bcd_updown_counter_digit u_digit (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (w_inc[gi]),
        .i_dec      (w_dec[gi]),
        .i_ld       (w_ld_ok),
        .i_ld_val   (bus.d[4*gi +: 4]),
        .i_wrap     (w_wrap),
        .i_wrap_val (w_wrap_val[4*gi +: 4]),
        .o_q        (w_q[4*gi +: 4]),
        .o_is9      (w_is9[gi]),
        .o_is0      (w_is0[gi])
      );
    end
  endgenerate

  // Load-error flag: high for the cycle after each rejected load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lderr <= 1'b0;
    end else begin
      r_lderr <= bus.ld & ~w_d_ok;
    end
  end

  assign bus.q     = w_q;
  assign bus.tc    = bus.en & ((bus.up & w_max_hit) | (~bus.up & w_zero));
  assign bus.lderr = r_lderr;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed testbench for bcd_updown_counter.
module tb_bcd_updown_counter;

  logic clk;
  logic rst;
  logic up_c;
  int   n_cmp;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(2)) if_a  ();
  bcd_updown_counter_if #(.DIGITS(2)) if_b  ();
  bcd_updown_counter_if #(.DIGITS(4)) if_c  ();
  bcd_updown_counter_if #(.DIGITS(2)) if_lo ();
  bcd_updown_counter_if #(.DIGITS(2)) if_hi ();

  bcd_updown_counter #(.DIGITS(2))                dut_a  (.i_clk(clk), .i_rst(rst), .bus(if_a.slave));
  bcd_updown_counter #(.DIGITS(2), .MAX(32'h59))  dut_b  (.i_clk(clk), .i_rst(rst), .bus(if_b.slave));
  bcd_updown_counter #(.DIGITS(4))                dut_c  (.i_clk(clk), .i_rst(rst), .bus(if_c.slave));
  bcd_updown_counter #(.DIGITS(2))                dut_lo (.i_clk(clk), .i_rst(rst), .bus(if_lo.slave));
  bcd_updown_counter #(.DIGITS(2))                dut_hi (.i_clk(clk), .i_rst(rst), .bus(if_hi.slave));

  assign if_hi.en = if_lo.tc;
  assign if_hi.up = up_c;
  assign if_lo.up = up_c;
  assign if_hi.ld = 1'b0;
  assign if_hi.d  = 8'h00;

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (if_a.q !== 8'h00) begin n_fail++; $display("FAIL reset_q_a: got %h want 00", if_a.q); end
    n_cmp++;
    if (if_c.q !== 16'h0000) begin n_fail++; $display("FAIL reset_q_c: got %h want 0000", if_c.q); end
    n_cmp++;
    if (if_b.lderr !== 1'b0) begin n_fail++; $display("FAIL reset_lderr: got %b want 0", if_b.lderr); end
    n_cmp++;
    if (if_a.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", if_a.tc); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_count_up();
    int exp_v;
    exp_v = 0;
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    for (int i = 0; i < 101; i++) begin
      #1;
      n_cmp++;
      if (if_a.tc !== (exp_v == 99)) begin n_fail++; $display("FAIL up_tc: q=%h got %b want %b", if_a.q, if_a.tc, (exp_v == 99)); end
      tick();
      exp_v = (exp_v + 1) % 100;
      n_cmp++;
      if (if_a.q !== to_bcd2(exp_v)) begin n_fail++; $display("FAIL up_q: got %h want %h", if_a.q, to_bcd2(exp_v)); end
    end
    if_a.en = 1'b0;
  endtask

  task automatic test_count_down();
    int exp_v;
    if_b.en = 1'b0;
    if_b.ld = 1'b1;
    if_b.d  = 8'h00;
    tick();
    n_cmp++;
    if (if_b.q !== 8'h00) begin n_fail++; $display("FAIL dn_load0: got %h want 00", if_b.q); end
    if_b.ld = 1'b0;
    if_b.en = 1'b1;
    if_b.up = 1'b0;
    exp_v = 0;
    for (int i = 0; i < 61; i++) begin
      #1;
      n_cmp++;
      if (if_b.tc !== (exp_v == 0)) begin n_fail++; $display("FAIL dn_tc: q=%h got %b want %b", if_b.q, if_b.tc, (exp_v == 0)); end
      tick();
      exp_v = (exp_v == 0) ? 59 : exp_v - 1;
      n_cmp++;
      if (if_b.q !== to_bcd2(exp_v)) begin n_fail++; $display("FAIL dn_q: got %h want %h", if_b.q, to_bcd2(exp_v)); end
    end
    if_b.en = 1'b0;
  endtask

  task automatic test_load();
    if_b.en = 1'b0;
    if_b.ld = 1'b1;
    if_b.d  = 8'h37;
    tick();
    n_cmp++;
    if (if_b.q !== 8'h37 || if_b.lderr !== 1'b0) begin n_fail++; $display("FAIL ld_37: q=%h lderr=%b want 37/0", if_b.q, if_b.lderr); end
    if_b.d = 8'h3A;
    tick();
    n_cmp++;
    if (if_b.q !== 8'h37 || if_b.lderr !== 1'b1) begin n_fail++; $display("FAIL ld_3A: q=%h lderr=%b want 37/1", if_b.q, if_b.lderr); end
    if_b.ld = 1'b0;
    tick();
    n_cmp++;
    if (if_b.lderr !== 1'b0) begin n_fail++; $display("FAIL ld_3A_fall: lderr=%b want 0", if_b.lderr); end
    if_b.ld = 1'b1;
    if_b.d  = 8'h60;
    tick();
    n_cmp++;
    if (if_b.q !== 8'h37 || if_b.lderr !== 1'b1) begin n_fail++; $display("FAIL ld_60: q=%h lderr=%b want 37/1", if_b.q, if_b.lderr); end
    if_b.d = 8'hA1;
    tick();
    n_cmp++;
    if (if_b.q !== 8'h37 || if_b.lderr !== 1'b1) begin n_fail++; $display("FAIL ld_b2b_rej: q=%h lderr=%b want 37/1", if_b.q, if_b.lderr); end
    if_b.d = 8'h59;
    tick();
    n_cmp++;
    if (if_b.q !== 8'h59 || if_b.lderr !== 1'b0) begin n_fail++; $display("FAIL ld_max: q=%h lderr=%b want 59/0", if_b.q, if_b.lderr); end
    if_b.ld = 1'b0;
    tick();
    n_cmp++;
    if (if_b.q !== 8'h59 || if_b.lderr !== 1'b0) begin n_fail++; $display("FAIL ld_hold: q=%h lderr=%b want 59/0", if_b.q, if_b.lderr); end
  endtask

  task automatic test_priority();
    if_a.ld = 1'b1;
    if_a.en = 1'b1;
    if_a.up = 1'b1;
    if_a.d  = 8'h12;
    tick();
    n_cmp++;
    if (if_a.q !== 8'h12) begin n_fail++; $display("FAIL prio_load: got %h want 12", if_a.q); end
    if_a.ld = 1'b0;
    tick();
    n_cmp++;
    if (if_a.q !== 8'h13) begin n_fail++; $display("FAIL prio_count: got %h want 13", if_a.q); end
    if_a.en = 1'b0;
  endtask

  task automatic test_async_reset();
    if_c.en = 1'b0;
    if_c.up = 1'b1;
    if_c.ld = 1'b1;
    if_c.d  = 16'h0486;
    tick();
    if_c.ld = 1'b0;
    if_c.en = 1'b1;
    tick();
    n_cmp++;
    if (if_c.q !== 16'h0487) begin n_fail++; $display("FAIL ar_pre: got %h want 0487", if_c.q); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (if_c.q !== 16'h0000) begin n_fail++; $display("FAIL ar_async: got %h want 0000", if_c.q); end
    tick();
    n_cmp++;
    if (if_c.q !== 16'h0000) begin n_fail++; $display("FAIL ar_held: got %h want 0000", if_c.q); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (if_c.q !== 16'h0001) begin n_fail++; $display("FAIL ar_resume: got %h want 0001", if_c.q); end
    if_c.en = 1'b0;
    if_c.ld = 1'b1;
    if_c.d  = 16'h0999;
    tick();
    if_c.ld = 1'b0;
    if_c.en = 1'b1;
    tick();
    n_cmp++;
    if (if_c.q !== 16'h1000) begin n_fail++; $display("FAIL c4_carry: got %h want 1000", if_c.q); end
    if_c.up = 1'b0;
    tick();
    n_cmp++;
    if (if_c.q !== 16'h0999) begin n_fail++; $display("FAIL c4_borrow: got %h want 0999", if_c.q); end
    if_c.en = 1'b0;
    if_c.ld = 1'b1;
    if_c.d  = 16'h0000;
    tick();
    if_c.ld = 1'b0;
    if_c.en = 1'b1;
    #1;
    n_cmp++;
    if (if_c.tc !== 1'b1) begin n_fail++; $display("FAIL c4_tc0: got %b want 1", if_c.tc); end
    tick();
    n_cmp++;
    if (if_c.q !== 16'h9999) begin n_fail++; $display("FAIL c4_wrapdn: got %h want 9999", if_c.q); end
    if_c.en = 1'b0;
  endtask

  task automatic test_cascade();
    int exp_v;
    up_c     = 1'b1;
    if_lo.ld = 1'b0;
    if_lo.d  = 8'h00;
    exp_v    = 0;
    n_cmp++;
    if ({if_hi.q, if_lo.q} !== 16'h0000) begin n_fail++; $display("FAIL casc_start: got %h want 0000", {if_hi.q, if_lo.q}); end
    if_lo.en = 1'b1;
    for (int i = 0; i < 10100; i++) begin
      tick();
      exp_v = (exp_v + 1) % 10000;
      n_cmp++;
      if ({if_hi.q, if_lo.q} !== to_bcd4(exp_v)) begin n_fail++; $display("FAIL casc_up: got %h want %h", {if_hi.q, if_lo.q}, to_bcd4(exp_v)); end
    end
    up_c = 1'b0;
    tick();
    n_cmp++;
    if ({if_hi.q, if_lo.q} !== 16'h0099) begin n_fail++; $display("FAIL casc_rev: got %h want 0099", {if_hi.q, if_lo.q}); end
    if_lo.en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    up_c   = 1'b1;
    if_a.en = 1'b0; if_a.up = 1'b1; if_a.ld = 1'b0; if_a.d = '0;
    if_b.en = 1'b0; if_b.up = 1'b1; if_b.ld = 1'b0; if_b.d = '0;
    if_c.en = 1'b0; if_c.up = 1'b1; if_c.ld = 1'b0; if_c.d = '0;
    if_lo.en = 1'b0; if_lo.ld = 1'b0; if_lo.d = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_async_reset();
    test_cascade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised N-digit BCD counter: up/down counting, programmable terminal value, synchronous parallel load with BCD validation, and a cascade-ready terminal-count output. It is the next generation of the team's fixed two-digit BCD counter. It serves as the building block for timer, clock-display and event-count datapaths, where several instances are chained through TC/EN.

## Interface
- DIGITS, 4, number of BCD digits (1..8); the count is 4*DIGITS bits wide.
- MAX, all digits 9 (e.g. 16'h9999 for DIGITS=4), terminal value in packed BCD. Every nibble must be ≤9; an invalid nibble is an elaboration error.
- CK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  count enable.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LD  input  1  synchronous load strobe.
- D  input  4*DIGITS  load value, packed BCD (digit 0 in D[3:0]).
- Q  output  4*DIGITS  count, packed BCD, registered.
- TC  output  1  terminal count, combinational: EN & ((UP & Q==MAX) | (!UP & Q==0)).
- LDERR  output  1  registered one-cycle pulse: the last LD was rejected.

## Operation
- Priority per edge: RST > LD > EN > hold.
- RST asserted: Q=0 and LDERR=0 immediately, independent of CK. While RST is high, all inputs are ignored.
- LD=1: D is accepted only if every nibble is ≤9 and D ≤ MAX.
  - Accepted: Q←D, LDERR←0.
  - Rejected: Q holds, LDERR←1 for one cycle.
  - EN is ignored in a load cycle.
- EN=1, LD=0, UP=1:
  - Q==MAX: Q←0 (wrap).
  - Otherwise digit i increments when all lower digits are 9. 9→0 within a digit. Digits above MAX never exceed it because the wrap is taken at MAX.
- EN=1, LD=0, UP=0:
  - Q==0: Q←MAX (wrap).
  - Otherwise digit i decrements when all lower digits are 0. 0→9 within a digit.
- EN=0, LD=0: Q holds. LDERR←0.
- Q never holds a non-BCD nibble or a value > MAX after reset.
- Comparing packed BCD as an unsigned binary value gives the correct numeric order. That comparison is used for the D ≤ MAX check.
- Cascading: the upper counter's EN is driven by the lower counter's TC. Both counters share CK and UP.

## Timing
- Count and load latency: Q updates on the same CK edge that samples EN/LD, so the new value is visible one cycle after the strobe.
- TC is combinational from EN, UP and Q; there is no register delay. It is high in exactly the cycle whose edge performs the wrap.
- LDERR goes high on the edge that samples the rejected LD. It falls on the next edge unless another rejected load occurs.
- UP change in the same cycle as EN: the new UP applies on that edge. There is no pipelining of direction.
- Reset mid-count: Q=0 asynchronously. Counting resumes on the first rising CK edge after RST falls with EN=1.
- Maximum combinational depth: the digit-enable chain of DIGITS stages plus the MAX/zero comparator.

## Structure
- Package bcd_pkg:
  - BCD_NINE = 4'h9;
  - a function validating that a packed BCD vector has all nibbles ≤9 (used for the MAX elaboration check and for D checking);
  - the function that builds the all-9s default MAX from DIGITS.
- Sub-module bcd_digit: one 4-bit digit register.
  - Inputs: CK, RST, inc, dec, ld, ld_val, wrap, wrap_val.
  - Outputs: q, is9, is0.
  - Generated DIGITS times.
  - The top level holds the carry/borrow chain, the MAX/zero compare, load validation and LDERR.

## Test plan
- Reset and count up (DIGITS=2, MAX=8'h99): RST pulse, then EN=1, UP=1 for 100 cycles -> Q=00,01..09,10..99,00. TC=1 only while Q=99. No nibble ever >9.
- Custom modulus down-count (DIGITS=2, MAX=8'h59): load 8'h00, then EN=1, UP=0 -> Q sequence 00,59,58..50,49..00. TC=1 only while Q=00.
- Load validation (DIGITS=2, MAX=8'h59), all with LD=1:
  - D=8'h37 -> Q=37, LDERR=0.
  - D=8'h3A -> Q stays 37, LDERR=1 for exactly one cycle.
  - D=8'h60 -> Q stays, LDERR pulses.
- Priority: LD=1, EN=1, UP=1, D=8'h12 -> Q=12, not 13. Next cycle with LD=0 -> Q=13.
- Asynchronous reset mid-count (DIGITS=4): at Q=16'h0487, assert RST between edges -> Q=0000 before the next edge. Release RST, EN=1 -> 0001 on the first edge.
- Cascade: two DIGITS=2 instances with the upper EN = lower TC, UP=1 for 10000 cycles -> combined {upper,lower} runs 0000..9999 and wraps to 0000. Then reverse UP at 0100 -> 0099.
